// File: rtl/ext_int_ctrl.sv
// ---------------------------------------------------------------------------
// ext_int_ctrl
//
// External interrupt controller feeding the ext_int input of the machine-mode
// CSR register file. Up to NUM_SRC asynchronous interrupt lines are
// synchronised, qualified by a per-source gateway (IDLE / PEND / INSVC plus
// an "again" flag) and arbitrated by enable, priority and threshold. Software
// takes a request with a claim (read of 0x0C) and returns it with a complete
// (write of 0x0C).
//
// Register map (byte offsets):
//   0x00 PENDING   RO  bit i-1 = source i pending
//   0x04 ENABLE    RW  bits [NUM_SRC-1:0]
//   0x08 THRESHOLD RW  bits [2:0]
//   0x0C CLAIM/COMPLETE  read = claim best ID, write [3:0] = complete ID
//   0x10 PRIORITY  RW  nibble i-1 = source i, bits [2:0] used
//
// Build option:
//   EXT_INT_EDGE_EN  defined   -> edge-triggered sources (rising edge of the
//                                 synchronised line, one history flop each)
//                    undefined -> level-sensitive sources
//
// Ports:
//   clk        in   core clock
//   rst_n      in   asynchronous active-low reset
//   irq_src_i  in   raw asynchronous interrupt lines, active-high
//   reg_req    in   single-cycle register access strobe
//   reg_wr     in   1 = write, 0 = read (qualified by reg_req)
//   reg_addr   in   word-aligned byte offset
//   reg_wdata  in   write data
//   reg_rdata  out  read data, combinational during a read, 0 otherwise
//   ext_int    out  registered interrupt request
// ---------------------------------------------------------------------------
module ext_int_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               reg_req,
    input  logic               reg_wr,
    input  logic [4:0]         reg_addr,
    input  logic [WIDTH-1:0]   reg_wdata,
    output logic [WIDTH-1:0]   reg_rdata,
    output logic               ext_int
);

    localparam logic [4:0] ADDR_PENDING   = 5'h00;
    localparam logic [4:0] ADDR_ENABLE    = 5'h04;
    localparam logic [4:0] ADDR_THRESHOLD = 5'h08;
    localparam logic [4:0] ADDR_CLAIM     = 5'h0C;
    localparam logic [4:0] ADDR_PRIORITY  = 5'h10;

`ifdef EXT_INT_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {
        GW_IDLE  = 2'd0,
        GW_PEND  = 2'd1,
        GW_INSVC = 2'd2
    } gw_state_e;

    logic [NUM_SRC-1:0] sync_meta;
    logic [NUM_SRC-1:0] sync;
    logic [NUM_SRC-1:0] trigger;

    gw_state_e          gw_state [NUM_SRC];
    gw_state_e          gw_next  [NUM_SRC];
    logic [NUM_SRC-1:0] again;
    logic [NUM_SRC-1:0] again_next;
    logic [NUM_SRC-1:0] pending;

    logic [NUM_SRC-1:0] enable;
    logic [2:0]         threshold;
    logic [2:0]         prio [NUM_SRC];

    logic               rd_en;
    logic               wr_en;
    logic               claim;
    logic               complete;
    logic [3:0]         complete_id;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;

    logic [3:0]         best_id;
    logic [2:0]         best_prio;

    // Only a handful of write-data bits are architecturally meaningful.
    logic               unused_wdata;
    assign unused_wdata = ^reg_wdata;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser per line
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= irq_src_i;
            sync      <= sync_meta;
        end
    end

`ifdef EXT_INT_EDGE_EN
    // History flop: a trigger is a 0->1 transition of the synchronised line.
    logic [NUM_SRC-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync;
        end
    end

    assign trigger = sync & ~sync_q;
`else
    assign trigger = sync;
`endif

    // -----------------------------------------------------------------------
    // Register access decode
    // -----------------------------------------------------------------------
    assign rd_en       = reg_req & ~reg_wr;
    assign wr_en       = reg_req & reg_wr;
    assign claim       = rd_en & (reg_addr == ADDR_CLAIM);
    assign complete    = wr_en & (reg_addr == ADDR_CLAIM);
    assign complete_id = reg_wdata[3:0];

    // -----------------------------------------------------------------------
    // Arbitration: highest priority above threshold wins. Scanning upward
    // with a strict compare keeps the lowest ID on a tie. Starting the
    // running maximum at the threshold makes priority <= threshold lose.
    // -----------------------------------------------------------------------
    always_comb begin
        best_id   = 4'd0;
        best_prio = threshold;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                best_id   = 4'(i + 1);
            end
        end
    end

    // A claim only ever hits the source named by best_id; an out-of-range
    // complete ID matches no source and is dropped.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_hit[i]    = claim && (best_id == 4'(i + 1));
            complete_hit[i] = complete && (complete_id == 4'(i + 1));
        end
    end

    // -----------------------------------------------------------------------
    // Gateway FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                gw_state[i] <= GW_IDLE;
            end
            again <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                gw_state[i] <= gw_next[i];
            end
            again <= again_next;
        end
    end

    // -----------------------------------------------------------------------
    // Gateway FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            gw_next[i] = gw_state[i];
        end
        again_next = again;

        for (int i = 0; i < NUM_SRC; i++) begin
            case (gw_state[i])
                GW_IDLE: begin
                    if (trigger[i]) begin
                        gw_next[i] = GW_PEND;
                    end
                end
                GW_PEND: begin
                    // Further triggers are absorbed; a coincident trigger on
                    // the claim edge is remembered for the next round.
                    if (claim_hit[i]) begin
                        gw_next[i]    = GW_INSVC;
                        again_next[i] = EDGE_MODE & trigger[i];
                    end
                end
                GW_INSVC: begin
                    if (complete_hit[i]) begin
                        gw_next[i]    = (again[i] || trigger[i]) ? GW_PEND : GW_IDLE;
                        again_next[i] = 1'b0;
                    end else if (EDGE_MODE && trigger[i]) begin
                        again_next[i] = 1'b1;
                    end
                end
                default: begin
                    gw_next[i]    = GW_IDLE;
                    again_next[i] = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Gateway FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending[i] = (gw_state[i] == GW_PEND);
        end
    end

    // -----------------------------------------------------------------------
    // Configuration registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= '0;
            threshold <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
        end else if (wr_en) begin
            case (reg_addr)
                ADDR_ENABLE:    enable    <= reg_wdata[NUM_SRC-1:0];
                ADDR_THRESHOLD: threshold <= reg_wdata[2:0];
                ADDR_PRIORITY: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        prio[i] <= reg_wdata[4*i +: 3];
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        reg_rdata = '0;
        if (rd_en) begin
            case (reg_addr)
                ADDR_PENDING:   reg_rdata[NUM_SRC-1:0] = pending;
                ADDR_ENABLE:    reg_rdata[NUM_SRC-1:0] = enable;
                ADDR_THRESHOLD: reg_rdata[2:0]         = threshold;
                ADDR_CLAIM:     reg_rdata[3:0]         = best_id;
                ADDR_PRIORITY: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        reg_rdata[4*i +: 3] = prio[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt request register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_int <= 1'b0;
        end else begin
            ext_int <= (best_id != 4'd0);
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Testbench for ext_int_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the
// controller's rules.
module tb_ext_int_ctrl;
    localparam int N = 8;

`ifdef EXT_INT_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq;
    logic          reg_req;
    logic          reg_wr;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic          ext_int;

    always #5 clk = ~clk;

    ext_int_ctrl #(.NUM_SRC(N), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src_i (irq),
        .reg_req   (reg_req),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .ext_int   (ext_int)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state: 0 = idle, 1 = waiting for claim, 2 = being serviced
    int          m_state [1:N];
    bit          m_again [1:N];
    bit          m_s1    [1:N];
    bit          m_sync  [1:N];
    bit          m_hist  [1:N];
    int          m_prio  [1:N];
    logic [N-1:0] m_en;
    int          m_thr;
    bit          m_ext;
    logic [31:0] last_rd;

    function automatic void m_reset();
        for (int i = 1; i <= N; i++) begin
            m_state[i] = 0; m_again[i] = 0;
            m_s1[i] = 0; m_sync[i] = 0; m_hist[i] = 0;
            m_prio[i] = 0;
        end
        m_en = '0; m_thr = 0; m_ext = 0;
    endfunction

    // Search priority levels from the top down; the first waiting, enabled
    // source found at a level is the lowest ID at that level.
    function automatic int m_best();
        for (int p = 7; p > m_thr; p--)
            for (int i = 1; i <= N; i++)
                if (m_state[i] == 1 && m_en[i-1] && m_prio[i] == p) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] r;
        r = 0;
        case (a)
            5'h00: for (int i = 1; i <= N; i++) if (m_state[i] == 1) r[i-1] = 1'b1;
            5'h04: r = 32'(m_en);
            5'h08: r = 32'(m_thr);
            5'h0C: r = 32'(m_best());
            5'h10: for (int i = 1; i <= N; i++) r = r | (32'(m_prio[i]) << (4*(i-1)));
            default: r = 0;
        endcase
        return r;
    endfunction

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic step();
        int best;
        bit trig [1:N];
        bit is_claim, is_cmpl;
        logic [31:0] exp_rd;
        #1;
        check("ext_int", ext_int, m_ext);
        exp_rd = (reg_req && !reg_wr) ? m_read(reg_addr) : 32'h0;
        check("rdata", reg_rdata, exp_rd);
        last_rd = reg_rdata;
        best = m_best();
        is_claim = reg_req && !reg_wr && reg_addr == 5'h0C;
        is_cmpl  = reg_req && reg_wr && reg_addr == 5'h0C;
        @(posedge clk);
        for (int i = 1; i <= N; i++) begin
            trig[i] = EDGE ? (m_sync[i] && !m_hist[i]) : m_sync[i];
            if (m_state[i] == 0) begin
                if (trig[i]) m_state[i] = 1;
            end else if (m_state[i] == 1) begin
                if (is_claim && best == i) begin
                    m_state[i] = 2;
                    m_again[i] = EDGE && trig[i];
                end
            end else begin
                if (is_cmpl && int'(reg_wdata[3:0]) == i) begin
                    m_state[i] = (m_again[i] || trig[i]) ? 1 : 0;
                    m_again[i] = 0;
                end else if (EDGE && trig[i]) begin
                    m_again[i] = 1;
                end
            end
        end
        if (reg_req && reg_wr) begin
            case (reg_addr)
                5'h04: m_en = reg_wdata[N-1:0];
                5'h08: m_thr = int'(reg_wdata[2:0]);
                5'h10: for (int i = 1; i <= N; i++) m_prio[i] = int'(reg_wdata[4*(i-1) +: 3]);
                default: ;
            endcase
        end
        m_ext = (best != 0);
        for (int i = 1; i <= N; i++) begin
            m_hist[i] = m_sync[i];
            m_sync[i] = m_s1[i];
            m_s1[i]   = irq[i-1];
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_req = 1; reg_wr = 1; reg_addr = a; reg_wdata = d;
        step();
        reg_req = 0; reg_wr = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        reg_req = 1; reg_wr = 0; reg_addr = a;
        step();
        d = last_rd;
        reg_req = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        irq = irq | mask;
        step();
        irq = irq & ~mask;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        check("rst_ext_int", ext_int, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    logic [31:0] d;

    initial begin
        rst_n = 0; irq = '0; reg_req = 0; reg_wr = 0; reg_addr = '0; reg_wdata = '0;
        m_reset();
        @(negedge clk);
        check("reset_ext_int", ext_int, 0);
        check("reset_rdata", reg_rdata, 0);
        rst_n = 1;

        // Reset then idle
        idle(20);
        rd(5'h00, d); check("idle_pending", d, 0);
        rd(5'h04, d); check("idle_enable", d, 0);
        rd(5'h08, d); check("idle_threshold", d, 0);
        rd(5'h10, d); check("idle_priority", d, 0);
        rd(5'h0C, d); check("idle_claim", d, 0);

        // Single source latency and claim/complete
        wr(5'h10, 32'h3); wr(5'h04, 32'h1); wr(5'h08, 32'h0);
        rd(5'h10, d); check("prio_readback", d, 32'h3);
        pulse(8'h01);                    // edge E0
        step();                          // E1
        step();                          // E2
        check("single_ext_e2", ext_int, 0);
        step();                          // E3
        check("single_ext_e3", ext_int, 1);
        rd(5'h00, d); check("single_pending", d, 32'h1);
        rd(5'h0C, d); check("single_claim", d, 32'h1);
        check("single_ext_ec", ext_int, 1);
        step();
        check("single_ext_ec1", ext_int, 0);
        wr(5'h0C, 32'h1);
        rd(5'h00, d); check("single_pending_after", d, 0);

        // Arbitration: equal priority -> lower ID first
        wr(5'h04, 32'hFF); wr(5'h10, 32'h0004_0040);
        pulse(8'h12); idle(4);
        rd(5'h0C, d); check("arb_tie_first", d, 2);
        rd(5'h0C, d); check("arb_tie_second", d, 5);
        wr(5'h0C, 32'h2); wr(5'h0C, 32'h5);
        wr(5'h10, 32'h0006_0040);
        pulse(8'h12); idle(4);
        rd(5'h0C, d); check("arb_prio_first", d, 5);
        rd(5'h0C, d); check("arb_prio_second", d, 2);
        wr(5'h0C, 32'h5); wr(5'h0C, 32'h2);
        wr(5'h0C, 32'h9);                // out-of-range complete, ignored

        // Threshold
        wr(5'h10, 32'h200); wr(5'h08, 32'h2);
        pulse(8'h04); idle(5);
        check("thr_blocked", ext_int, 0);
        wr(5'h08, 32'h1);
        check("thr_write_edge", ext_int, 0);
        step();
        check("thr_open", ext_int, 1);
        rd(5'h0C, d); check("thr_claim", d, 3);
        wr(5'h0C, 32'h3);
        wr(5'h08, 32'h0);

        // Re-trigger while in service
        wr(5'h10, 32'h3);
        pulse(8'h01); idle(4);
        rd(5'h0C, d); check("retrig_claim1", d, 1);
        if (EDGE) begin
            pulse(8'h01); idle(3);
        end else begin
            irq[0] = 1'b1; idle(3);
        end
        wr(5'h0C, 32'h1);
        rd(5'h00, d); check("retrig_pending", d, 32'h1);
        rd(5'h0C, d); check("retrig_claim2", d, 1);
        irq[0] = 1'b0; idle(3);
        wr(5'h0C, 32'h1);
        rd(5'h00, d); check("retrig_done", d, 0);

        // Reset mid-service
        wr(5'h10, 32'h5000);
        pulse(8'h08); idle(4);
        rd(5'h0C, d); check("rst_claim", d, 4);
        do_reset();
        check("rst_mid_ext", ext_int, 0);
        rd(5'h00, d); check("rst_mid_pending", d, 0);
        wr(5'h0C, 32'h4);
        rd(5'h00, d); check("rst_cmpl_pending", d, 0);
        wr(5'h04, 32'hFF); wr(5'h10, 32'h5000);
        rd(5'h0C, d); check("rst_claim_none", d, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            irq = irq ^ (N'($urandom) & N'($urandom) & N'($urandom));
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else if (r <= 2) begin
                rd(5'h0C, d);
            end else if (r == 3) begin
                wr(5'h0C, $urandom_range(0, 1) ? 32'($urandom_range(1, N)) : 32'($urandom_range(0, 15)));
            end else if (r == 4) begin
                rd(5'($urandom_range(0, 7) << 2), d);
            end else if (r == 5) begin
                wr(5'($urandom_range(0, 7) << 2), $urandom);
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
